sccb_target: RTL

- SCCB responder (slave) for the camera configuration bus; the other end of the SCCB master that drives sioc/siod.
- Oversamples sioc/siod on the system clock, decodes 3-phase write and 2-phase read cycles, and holds an internal register file.
- Emits a write strobe per accepted data byte.
- Used as an OV7670 stand-in for loopback and simulation of the camera configuration path.

---
 rtl/sccb_target_if.sv | 24 ++
 rtl/sccb_target.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sccb_target_if.sv
// SCCB target bundle: pad lines, write strobe, busy flag and the bench debug read port.
interface sccb_target_if #(
    parameter int REG_AW = 8
);
    logic              sioc;
    logic              siod_in;
    logic              siod_oe;
    logic              wr_valid;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic [REG_AW-1:0] dbg_addr;
    logic [7:0]        dbg_data;

    modport master (
        output sioc, siod_in, dbg_addr,
        input  siod_oe, wr_valid, wr_addr, wr_data, busy, dbg_data
    );

    modport slave (
        input  sioc, siod_in, dbg_addr,
        output siod_oe, wr_valid, wr_addr, wr_data, busy, dbg_data
    );
endinterface

// File: rtl/sccb_target.sv
// SCCB responder with internal register file, oversampling sioc/siod on clk.
// Define SCCB_TARGET_ACK_EN to drive siod low during the 9th bit of accepted bytes.
module sccb_target #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    sccb_target_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ID     = 3'd1;
    localparam logic [2:0] ST_SUB    = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_RD     = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

`ifdef SCCB_TARGET_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
    logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
    logic                   sioc_prev_q, sioc_prev_d;
    logic                   siod_prev_q, siod_prev_d;
    logic [2:0]             state_q, state_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [REG_AW-1:0]      ptr_q, ptr_d;
    logic                   pend_q, pend_d;
    logic                   oe_q, oe_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             regs_q [2**REG_AW];

    logic       sioc_s, siod_s;
    logic       sioc_rise, sioc_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic [7:0] rd_shifted;

    assign sioc_s     = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s     = siod_sync_q[SYNC_STAGES-1];
    assign sioc_rise  = sioc_s & ~sioc_prev_q;
    assign sioc_fall  = ~sioc_s & sioc_prev_q;
    assign start_det  = sioc_s & siod_prev_q & ~siod_s;
    assign stop_det   = sioc_s & ~siod_prev_q & siod_s;
    assign rx_byte    = {shift_q[6:0], siod_s};
    assign rd_byte    = regs_q[ptr_q];
    assign rd_shifted = rd_byte << bitcnt_q[2:0];

    always_comb begin
        // NOTE: every _d starts from a default so no branch below can leave one unassigned (no latches).
        sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], bus.sioc};
        siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], bus.siod_in};
        sioc_prev_d = sioc_s;
        siod_prev_d = siod_s;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        pend_d      = 1'b0;
        oe_d        = oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // A byte completed in WR on the previous enabled cycle is committed here.
        if (pend_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + REG_AW'(1);
        end

        if (start_det) begin
            state_d  = ST_ID;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ID, ST_SUB, ST_WR: begin
                    if (sioc_fall) oe_d = ACK_EN && (bitcnt_q == 4'd8);
                    if (sioc_rise) begin
                        if (bitcnt_q != 4'd8) begin
                            shift_d  = rx_byte;
                            bitcnt_d = bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (state_q == ST_ID && rx_byte[7:1] != DEV_ID[7:1]) begin
                                    state_d  = ST_IGNORE;
                                    bitcnt_d = 4'd0;
                                end
                                if (state_q == ST_SUB) ptr_d  = REG_AW'(rx_byte);
                                if (state_q == ST_WR)  pend_d = 1'b1;
                            end
                        end else begin
                            bitcnt_d = 4'd0;
                            if (state_q == ST_ID)       state_d = shift_q[0] ? ST_RD : ST_SUB;
                            else if (state_q == ST_SUB) state_d = ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    // Data changes on sioc fall; the fall before the 9th bit releases for the master NA.
                    if (sioc_fall) oe_d = (bitcnt_q == 4'd8) ? 1'b0 : ~rd_shifted[7];
                    if (sioc_rise) begin
                        if (bitcnt_q != 4'd8) begin
                            bitcnt_d = bitcnt_q + 4'd1;
                        end else begin
                            bitcnt_d = 4'd0;
                            if (siod_s) state_d = ST_IGNORE;
                            else        ptr_d   = ptr_q + REG_AW'(1);
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: oe_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
        if (rst) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= '0;
            pend_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
        end else if (clk_en) begin
            sioc_sync_q <= sioc_sync_d;
            siod_sync_q <= siod_sync_d;
            sioc_prev_q <= sioc_prev_d;
            siod_prev_q <= siod_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            oe_q        <= oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // NOTE: the register file has no reset; its contents survive rst like the real sensor's.
    always_ff @(posedge clk) begin
        if (!rst && clk_en && pend_q) regs_q[ptr_q] <= shift_q;
    end

    assign bus.siod_oe  = oe_q;
    assign bus.wr_valid = wr_valid_q & clk_en;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.dbg_data = regs_q[bus.dbg_addr];
endmodule
